// File: rtl/timing_manager_nch_pkg.sv
// Shared types and default sizing for the sensor-acquisition scheduler.
package timing_mgr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_SENS_DEF  = 10;
  localparam int TIME_W_DEF  = 16;
  localparam int CNT_W_DEF   = 32;
  localparam int RATIO_W_DEF = 16;
  localparam int OVR_W_DEF   = 8;

endpackage

// File: rtl/timing_manager_nch_if.sv
// Control/status bundle between the register file/PWM side (master) and the scheduler (slave).
// Inputs are levels or single-cycle pulses sampled on clk; there is no valid/ready back-pressure.
interface timing_manager_nch_if
  import timing_mgr_pkg::*;
#(
  parameter int N_SENS  = N_SENS_DEF,
  parameter int TIME_W  = TIME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int RATIO_W = RATIO_W_DEF,
  parameter int OVR_W   = OVR_W_DEF
);
  logic                       do_auto_triggering;
  logic                       send_manual_trigger;
  logic                       event_qualifier;
  logic [RATIO_W-1:0]         user_ratio;
  logic [N_SENS-1:0]          en_bits;
  logic [N_SENS-1:0]          done;
  logic [CNT_W-1:0]           timeout_cycles;
  logic                       reset_sched_isr;
  logic                       clear_status;

  logic [N_SENS-1:0]          en_out;
  logic                       trigger;
  logic                       sched_isr;
  logic                       busy;
  logic [CNT_W-1:0]           count_time;
  logic [N_SENS*TIME_W-1:0]   time_flat;
  logic [N_SENS-1:0]          timeout_flags;
  logic [OVR_W-1:0]           overrun_cnt;
  state_t                     dbg_state;

  modport master (
    output do_auto_triggering, send_manual_trigger, event_qualifier, user_ratio,
           en_bits, done, timeout_cycles, reset_sched_isr, clear_status,
    input  en_out, trigger, sched_isr, busy, count_time, time_flat,
           timeout_flags, overrun_cnt, dbg_state
  );

  modport slave (
    input  do_auto_triggering, send_manual_trigger, event_qualifier, user_ratio,
           en_bits, done, timeout_cycles, reset_sched_isr, clear_status,
    output en_out, trigger, sched_isr, busy, count_time, time_flat,
           timeout_flags, overrun_cnt, dbg_state
  );
endinterface

// File: rtl/timing_manager_nch_channel.sv
// One sensor channel: done rising-edge detect, once-per-acquisition latch, saturating time capture.
module tm_channel #(
  parameter int TIME_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              acq_i,
  input  logic              done_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              latched_o,
  output logic [TIME_W-1:0] time_o
);
  localparam logic [CNT_W-1:0] TIME_MAX = CNT_W'({TIME_W{1'b1}});

  logic              done_prev_q;
  logic              latched_q, latched_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              rise;

  // Previous level is tracked continuously so an edge seen outside ACQ is never replayed later.
  assign rise = done_i && !done_prev_q;

  always_comb begin
    latched_d = latched_q;
    time_d    = time_q;
    if (start_i) begin
      latched_d = 1'b0;
    end else if (acq_i && rise && !latched_q) begin
      latched_d = 1'b1;
      time_d    = (count_i > TIME_MAX) ? {TIME_W{1'b1}} : count_i[TIME_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_prev_q <= 1'b0;
      latched_q   <= 1'b0;
      time_q      <= '0;
    end else begin
      done_prev_q <= done_i;
      latched_q   <= latched_d;
      time_q      <= time_d;
    end
  end

  assign latched_o = latched_q;
  assign time_o    = time_q;
endmodule

// File: rtl/timing_manager_nch.sv
// Sensor-acquisition scheduler: ratio/manual triggering, per-acquisition enable snapshot,
// completion/timeout FSM, free-running acquisition timer and saturating overrun counter.
module timing_manager_nch
  import timing_mgr_pkg::*;
#(
  parameter int N_SENS  = N_SENS_DEF,
  parameter int TIME_W  = TIME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int RATIO_W = RATIO_W_DEF,
  parameter int OVR_W   = OVR_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  timing_manager_nch_if.slave bus
);
  state_t                   state_q, state_d;
  logic [RATIO_W-1:0]       ev_q, ev_d;
  logic                     queue_q, queue_d;
  logic                     trig_q, trig_d;
  logic                     isr_q, isr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [N_SENS-1:0]        en_snap_q, en_snap_d;
  logic [N_SENS-1:0]        flags_q, flags_d;
  logic [OVR_W-1:0]         ovr_q, ovr_d;
  logic [N_SENS-1:0]        latched;
  logic [N_SENS*TIME_W-1:0] time_flat;
  logic                     ratio_hit, in_acq, all_done, timeout_hit;

  assign ratio_hit = bus.event_qualifier && (ev_q == bus.user_ratio);
  assign in_acq    = (state_q == ACQ);
  assign all_done  = &(latched | ~en_snap_q);
  // The timer still holds the previous acquisition's value while the trigger pulse is out.
  assign timeout_hit = in_acq && !trig_q && (bus.timeout_cycles != '0) &&
                       (cnt_q == bus.timeout_cycles);

  always_comb begin
    state_d   = state_q;
    ev_d      = ev_q;
    queue_d   = queue_q;
    isr_d     = isr_q;
    cnt_d     = trig_q ? '0 : cnt_q + CNT_W'(1);
    en_snap_d = en_snap_q;
    flags_d   = flags_q;
    ovr_d     = ovr_q;

    if (bus.event_qualifier) ev_d = ratio_hit ? '0 : ev_q + RATIO_W'(1);

    trig_d = !in_acq && (|bus.en_bits) &&
             ((bus.do_auto_triggering && ratio_hit) || (queue_q && bus.event_qualifier));

    if (trig_d)                  queue_d = 1'b0;
    if (bus.send_manual_trigger) queue_d = 1'b1;
    if (bus.reset_sched_isr)     isr_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (trig_d) begin
          state_d   = ACQ;
          en_snap_d = bus.en_bits;
          flags_d   = '0;
        end
      end
      ACQ: begin
        if (all_done) begin
          state_d = DONE;
          isr_d   = 1'b1;
        end else if (timeout_hit) begin
          state_d = DONE;
          isr_d   = 1'b1;
          flags_d = en_snap_q & ~latched;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.clear_status) begin
      ovr_d = '0;
    end else if (ratio_hit && bus.do_auto_triggering && in_acq && (ovr_q != '1)) begin
      ovr_d = ovr_q + OVR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ev_q      <= '0;
      queue_q   <= 1'b0;
      trig_q    <= 1'b0;
      isr_q     <= 1'b0;
      cnt_q     <= '0;
      en_snap_q <= '0;
      flags_q   <= '0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      ev_q      <= ev_d;
      queue_q   <= queue_d;
      trig_q    <= trig_d;
      isr_q     <= isr_d;
      cnt_q     <= cnt_d;
      en_snap_q <= en_snap_d;
      flags_q   <= flags_d;
      ovr_q     <= ovr_d;
    end
  end

  for (genvar i = 0; i < N_SENS; i++) begin : g_ch
    tm_channel #(
      .TIME_W (TIME_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (trig_d),
      .acq_i     (in_acq),
      .done_i    (bus.done[i]),
      .count_i   (cnt_q),
      .latched_o (latched[i]),
      .time_o    (time_flat[i*TIME_W +: TIME_W])
    );
  end

  assign bus.en_out        = bus.en_bits;
  assign bus.trigger       = trig_q;
  assign bus.sched_isr     = isr_q;
  assign bus.busy          = in_acq;
  assign bus.count_time    = cnt_q;
  assign bus.time_flat     = time_flat;
  assign bus.timeout_flags = flags_q;
  assign bus.overrun_cnt   = ovr_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_timing_manager_nch.sv
// Scenario bench for timing_manager_nch, built with TIME_W=8 so time saturation is reachable.
module tb_timing_manager_nch;
  import timing_mgr_pkg::*;

  localparam int N_SENS  = 10;
  localparam int TIME_W  = 8;
  localparam int CNT_W   = 32;
  localparam int RATIO_W = 16;
  localparam int OVR_W   = 8;
  localparam int FLAT_W  = N_SENS * TIME_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timing_manager_nch_if #(
    .N_SENS(N_SENS), .TIME_W(TIME_W), .CNT_W(CNT_W), .RATIO_W(RATIO_W), .OVR_W(OVR_W)
  ) bus ();

  timing_manager_nch #(
    .N_SENS(N_SENS), .TIME_W(TIME_W), .CNT_W(CNT_W), .RATIO_W(RATIO_W), .OVR_W(OVR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [FLAT_W-1:0] exp_q[$];
  logic [TIME_W-1:0] model_time[N_SENS];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.do_auto_triggering  = 1'b0;
    bus.send_manual_trigger = 1'b0;
    bus.event_qualifier     = 1'b0;
    bus.user_ratio          = '0;
    bus.en_bits             = '0;
    bus.done                = '0;
    bus.timeout_cycles      = '0;
    bus.reset_sched_isr     = 1'b0;
    bus.clear_status        = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Queue a manual request, then one qualifier; returns the trigger level seen after it.
  // On return the acquisition timer reads 0.
  task automatic start_manual(output logic trig_seen);
    bus.send_manual_trigger = 1'b1;
    step();
    bus.send_manual_trigger = 1'b0;
    bus.event_qualifier = 1'b1;
    step();
    bus.event_qualifier = 1'b0;
    trig_seen = bus.trigger;
    step();
  endtask

  task automatic clear_isr();
    bus.reset_sched_isr = 1'b1;
    step();
    bus.reset_sched_isr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    apply_reset();
    n_vec++;
    if (bus.trigger !== 1'b0 || bus.sched_isr !== 1'b0 || bus.busy !== 1'b0 ||
        bus.time_flat !== '0 || bus.timeout_flags !== '0 || bus.overrun_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: trig=%b isr=%b busy=%b flat=%h flags=%h ovr=%0d, all required 0",
               bus.trigger, bus.sched_isr, bus.busy, bus.time_flat, bus.timeout_flags, bus.overrun_cnt);
    end
    n_vec++;
    if (bus.dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d required %0d", bus.dbg_state, IDLE);
    end
  endtask

  task automatic test_auto_ratio();
    bus.user_ratio = 16'd3;
    bus.en_bits = 10'h001;
    bus.do_auto_triggering = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.event_qualifier = 1'b1;
      step();
      bus.event_qualifier = 1'b0;
      n_vec++;
      if (bus.trigger !== (k == 3)) begin
        n_err++;
        $display("FAIL auto_trigger_q%0d: got %b required %b", k, bus.trigger, (k == 3));
      end
      if (k < 3) step();
    end
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL auto_busy: got %b required 1", bus.busy);
    end
    step();
    n_vec++;
    if (bus.count_time !== 32'd0 || bus.trigger !== 1'b0) begin
      n_err++;
      $display("FAIL auto_timer_start: count=%0d trig=%b required 0/0", bus.count_time, bus.trigger);
    end
    repeat (50) step();
    bus.done = 10'h001;
    step();
    bus.done = '0;
    step();
    n_vec++;
    if (bus.time_flat[7:0] !== 8'd50 || bus.sched_isr !== 1'b1 || bus.dbg_state !== DONE) begin
      n_err++;
      $display("FAIL auto_complete: time0=%0d isr=%b state=%0d required 50/1/%0d",
               bus.time_flat[7:0], bus.sched_isr, bus.dbg_state, DONE);
    end
    clear_isr();
    n_vec++;
    if (bus.sched_isr !== 1'b0) begin
      n_err++;
      $display("FAIL auto_isr_clear: got %b required 0", bus.sched_isr);
    end
    bus.do_auto_triggering = 1'b0;
  endtask

  task automatic test_manual();
    logic any_trig;
    bus.en_bits = '0;
    bus.send_manual_trigger = 1'b1;
    step();
    bus.send_manual_trigger = 1'b0;
    bus.event_qualifier = 1'b1;
    step();
    bus.event_qualifier = 1'b0;
    n_vec++;
    if (bus.trigger !== 1'b0 || bus.dbg_state !== DONE) begin
      n_err++;
      $display("FAIL manual_no_enable: trig=%b state=%0d required 0/%0d", bus.trigger, bus.dbg_state, DONE);
    end
    bus.en_bits = 10'h001;
    any_trig = 1'b0;
    repeat (10) begin
      step();
      any_trig = any_trig | bus.trigger;
    end
    n_vec++;
    if (any_trig !== 1'b0) begin
      n_err++;
      $display("FAIL manual_wait_for_qualifier: trigger seen %b required 0", any_trig);
    end
    bus.event_qualifier = 1'b1;
    step();
    bus.event_qualifier = 1'b0;
    n_vec++;
    if (bus.trigger !== 1'b1) begin
      n_err++;
      $display("FAIL manual_trigger: got %b required 1", bus.trigger);
    end
    step();
    n_vec++;
    if (bus.trigger !== 1'b0) begin
      n_err++;
      $display("FAIL manual_single_pulse: got %b required 0", bus.trigger);
    end
    repeat (5) step();
    bus.done = 10'h001;
    step();
    bus.done = '0;
    step();
    bus.event_qualifier = 1'b1;
    step();
    bus.event_qualifier = 1'b0;
    n_vec++;
    if (bus.trigger !== 1'b0 || bus.dbg_state !== DONE || bus.time_flat[7:0] !== 8'd5) begin
      n_err++;
      $display("FAIL manual_queue_cleared: trig=%b state=%0d time0=%0d required 0/%0d/5",
               bus.trigger, bus.dbg_state, bus.time_flat[7:0], DONE);
    end
    clear_isr();
  endtask

  task automatic test_timeout();
    logic t;
    bus.timeout_cycles = 32'd100;
    bus.en_bits = 10'h005;
    start_manual(t);
    n_vec++;
    if (t !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_trigger: got %b required 1", t);
    end
    repeat (10) step();
    bus.done = 10'h001;
    step();
    bus.done = '0;
    repeat (89) step();
    n_vec++;
    if (bus.count_time !== 32'd100 || bus.dbg_state !== ACQ || bus.timeout_flags !== '0) begin
      n_err++;
      $display("FAIL timeout_before: count=%0d state=%0d flags=%h required 100/%0d/0",
               bus.count_time, bus.dbg_state, bus.timeout_flags, ACQ);
    end
    step();
    n_vec++;
    if (bus.timeout_flags !== 10'h004 || bus.dbg_state !== DONE || bus.sched_isr !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_fire: flags=%h state=%0d isr=%b required 004/%0d/1",
               bus.timeout_flags, bus.dbg_state, bus.sched_isr, DONE);
    end
    clear_isr();
    bus.timeout_cycles = '0;
  endtask

  task automatic test_overrun();
    apply_reset();
    bus.user_ratio = '0;
    bus.en_bits = 10'h001;
    bus.do_auto_triggering = 1'b1;
    bus.event_qualifier = 1'b1;
    step();
    repeat (100) step();
    n_vec++;
    if (bus.overrun_cnt !== 8'd100) begin
      n_err++;
      $display("FAIL overrun_count: got %0d required 100", bus.overrun_cnt);
    end
    repeat (200) step();
    n_vec++;
    if (bus.overrun_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL overrun_saturate: got %0d required 255", bus.overrun_cnt);
    end
    bus.clear_status = 1'b1;
    step();
    bus.clear_status = 1'b0;
    n_vec++;
    if (bus.overrun_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL overrun_clear_wins: got %0d required 0", bus.overrun_cnt);
    end
    step();
    n_vec++;
    if (bus.overrun_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL overrun_after_clear: got %0d required 1", bus.overrun_cnt);
    end
    bus.event_qualifier = 1'b0;
    bus.do_auto_triggering = 1'b0;
    bus.done = 10'h001;
    step();
    bus.done = '0;
    step();
    n_vec++;
    if (bus.dbg_state !== DONE || bus.sched_isr !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_exit: state=%0d isr=%b required %0d/1", bus.dbg_state, bus.sched_isr, DONE);
    end
    clear_isr();
  endtask

  task automatic test_saturate_snapshot();
    logic t;
    bus.en_bits = 10'h002;
    start_manual(t);
    bus.en_bits = 10'h3ff;
    repeat (300) step();
    bus.done = 10'h002;
    step();
    bus.done = '0;
    step();
    n_vec++;
    if (t !== 1'b1 || bus.time_flat[15:8] !== 8'd255 || bus.dbg_state !== DONE ||
        bus.en_out !== 10'h3ff) begin
      n_err++;
      $display("FAIL saturate_snapshot: trig=%b time1=%0d state=%0d en_out=%h required 1/255/%0d/3ff",
               t, bus.time_flat[15:8], bus.dbg_state, DONE, bus.en_out);
    end
    clear_isr();
  endtask

  task automatic test_reset_mid();
    logic t;
    bus.en_bits = 10'h001;
    start_manual(t);
    repeat (20) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.count_time !== '0 || bus.time_flat !== '0 ||
        bus.sched_isr !== 1'b0 || bus.trigger !== 1'b0 || bus.dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL async_reset: busy=%b count=%0d flat=%h isr=%b trig=%b state=%0d required all 0/IDLE",
               bus.busy, bus.count_time, bus.time_flat, bus.sched_isr, bus.trigger, bus.dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start_manual(t);
    repeat (7) step();
    bus.done = 10'h001;
    step();
    bus.done = '0;
    step();
    n_vec++;
    if (t !== 1'b1 || bus.time_flat[7:0] !== 8'd7 || bus.sched_isr !== 1'b1) begin
      n_err++;
      $display("FAIL after_reset_acq: trig=%b time0=%0d isr=%b required 1/7/1",
               t, bus.time_flat[7:0], bus.sched_isr);
    end
    clear_isr();
  endtask

  // Reference: channel i pulses done at timer value m[i] (or never). The acquisition ends at
  // completion (timer = last enabled pulse + 1) unless the watchdog limit comes strictly earlier.
  task automatic test_random();
    int m[N_SENS];
    bit never[N_SENS];
    logic [N_SENS-1:0] en, exp_flags;
    logic [FLAT_W-1:0] exp_flat, got_flat;
    int tmo, last, c_end;
    bit any_never;
    logic t;
    apply_reset();
    for (int i = 0; i < N_SENS; i++) model_time[i] = '0;
    for (int it = 0; it < 25; it++) begin
      en = N_SENS'($urandom_range(1, 1023));
      tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(5, 60));
      last = -1;
      any_never = 1'b0;
      for (int i = 0; i < N_SENS; i++) begin
        m[i] = int'($urandom_range(0, 70));
        never[i] = ($urandom_range(0, 4) == 0) && !(tmo == 0 && en[i]);
        if (en[i]) begin
          if (never[i]) any_never = 1'b1;
          else if (m[i] > last) last = m[i];
        end
      end
      exp_flags = '0;
      if (tmo != 0 && (any_never || tmo < last + 1)) begin
        c_end = tmo;
        for (int i = 0; i < N_SENS; i++)
          exp_flags[i] = en[i] && (never[i] || m[i] >= tmo);
      end else begin
        c_end = last + 1;
      end
      for (int i = 0; i < N_SENS; i++)
        if (!never[i] && m[i] <= c_end) model_time[i] = TIME_W'(m[i]);
      for (int i = 0; i < N_SENS; i++) exp_flat[i*TIME_W +: TIME_W] = model_time[i];
      exp_q.push_back(exp_flat);

      bus.timeout_cycles = CNT_W'(tmo);
      bus.en_bits = en;
      start_manual(t);
      bus.en_bits = N_SENS'($urandom_range(0, 1023));
      for (int c = 0; c <= 80; c++) begin
        for (int i = 0; i < N_SENS; i++) bus.done[i] = !never[i] && (m[i] == c);
        step();
      end
      bus.done = '0;

      got_flat = bus.time_flat;
      n_vec++;
      if (t !== 1'b1 || bus.dbg_state !== DONE || bus.sched_isr !== 1'b1 || bus.count_time !== 32'd81) begin
        n_err++;
        $display("FAIL rand%0d_state: trig=%b state=%0d isr=%b count=%0d required 1/%0d/1/81",
                 it, t, bus.dbg_state, bus.sched_isr, bus.count_time, DONE);
      end
      n_vec++;
      if (bus.timeout_flags !== exp_flags) begin
        n_err++;
        $display("FAIL rand%0d_flags: got %h required %h", it, bus.timeout_flags, exp_flags);
      end
      exp_flat = exp_q.pop_front();
      n_vec++;
      if (got_flat !== exp_flat) begin
        n_err++;
        $display("FAIL rand%0d_times: got %h required %h", it, got_flat, exp_flat);
      end
      clear_isr();
    end
    bus.timeout_cycles = '0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_auto_ratio();
    test_manual();
    test_timeout();
    test_overrun();
    test_saturate_snapshot();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
